dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-ported data memory between two requesters: the CPU data port (port C) and the program/debug loader (port L).
It serialises accesses, holds them for a fixed memory latency and returns a one-cycle acknowledge.
It also drives a stall signal that the top level uses to gate the CPU enable while a CPU access is pending.
Arbitration is round-robin on simultaneous requests.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width
LAT, 2, memory access cycles per transaction (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
c_req  input  1  CPU request, held until c_ack
c_we  input  1  CPU write (1) / read (0)
c_addr  input  ADDR_W  CPU address
c_wdata  input  DATA_W  CPU write data
c_rdata  output  DATA_W  CPU read data, valid while c_ack=1
c_ack  output  1  CPU transaction complete, one-cycle pulse
l_req, l_we, l_addr, l_wdata, l_rdata, l_ack  same widths/meanings as the c_* ports, for the loader
m_ena  output  1  memory enable
m_w  output  1  memory write strobe
m_r  output  1  memory read strobe
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data
cpu_stall  output  1  c_req & ~c_ack (combinational)
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0.
  - owner=C, last_grant=L, so the CPU wins the first tie.
  - c_rdata=l_rdata=0, c_ack=l_ack=0.
  - m_ena=m_w=m_r=0, m_addr=m_wdata=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If only one of c_req/l_req is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On grant: latch owner, we, addr and wdata from the granted port; cnt<=LAT-1; go to ACCESS.
- ACCESS:
  - m_ena=1; m_w=latched we; m_r=~latched we; m_addr/m_wdata come from the latched registers (stable for all LAT cycles).
  - cnt decrements each cycle.
  - On the cycle with cnt==0: for a read, register m_rdata into owner's rdata; go to DONE.
- DONE:
  - m_ena=m_w=m_r=0.
  - Owner's ack=1 for exactly this cycle; the other ack stays 0.
  - last_grant<=owner; go to IDLE.
- Latency: a request first seen high in IDLE at cycle k produces ack in cycle k+LAT+1. With LAT=2 that is 3 cycles after the request.
- Throughput: one transaction per LAT+2 cycles.
- Requests arriving in ACCESS or DONE are not sampled until the next IDLE cycle.
- A req still high in the IDLE cycle after DONE is treated as a new transaction. A requester must drop req in the cycle after ack unless it intends a back-to-back access.
- Request withdrawn during ACCESS: the transaction still completes, and ack is still issued.
- Address/data changes on a requester during ACCESS: ignored, because latched values are used.
- Write transaction: the owner's rdata register keeps its previous value.
- rdata registers hold their value until the next read completes for that port.
- Reset mid-transaction: the access is aborted immediately (m_ena drops asynchronously) and no ack is issued. The memory write may or may not have landed; that is acceptable.
- cpu_stall is combinational. It is 1 from the cycle c_req rises until the c_ack cycle, where it is 0, letting the CPU advance exactly one instruction.

Test Plan:
- CPU read, LAT=2: mem[0x10]=0xDEADBEEF; c_req=1, c_we=0, c_addr=0x10 at cycle 0.
  -> m_r=1 and m_addr=0x10 in cycles 1-2; c_ack=1 with c_rdata=0xDEADBEEF in cycle 3; cpu_stall=1 in cycles 0-2 and 0 in cycle 3.
- Loader write: l_we=1, l_addr=0x20, l_wdata=0x12345678.
  -> m_w=1 for 2 cycles; l_ack in cycle 3; mem[0x20]=0x12345678; l_rdata unchanged.
- Simultaneous requests held high for 4 transactions from reset.
  -> grant order C, L, C, L; acks at cycles 3, 7, 11, 15.
- CPU keeps c_req high for back-to-back reads of 0x0, 0x4.
  -> two acks exactly 4 cycles apart; each c_rdata matches its address.
- rst asserted in cycle 2 of a CPU write.
  -> m_ena=0 immediately, no c_ack, state=IDLE; last_grant=L, so the next tie goes to C.
- l_req dropped and l_addr changed during ACCESS.
  -> m_addr stays at the latched value; l_ack is still pulsed in cycle LAT+1.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU (C)
// and the loader (L); each access holds the memory for LAT cycles, then acks once.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_ack,
  output logic              m_ena,
  output logic              m_w,
  output logic              m_r,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              cpu_stall,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic       PORT_C   = 1'b0;
  localparam logic       PORT_L   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              owner_q;
  logic              last_grant_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] c_rdata_q;
  logic [DATA_W-1:0] l_rdata_q;
  logic              c_ack_q;
  logic              l_ack_q;
  logic              m_ena_q;
  logic              m_w_q;
  logic              m_r_q;

  logic              grant_l_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  // On a tie the port that did not win the previous transaction is granted.
  always_comb begin
    grant_l_d = l_req & (~c_req | (last_grant_q == PORT_C));
    we_d      = grant_l_d ? l_we    : c_we;
    addr_d    = grant_l_d ? l_addr  : c_addr;
    wdata_d   = grant_l_d ? l_wdata : c_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= PORT_C;
      last_grant_q <= PORT_L;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      c_rdata_q    <= '0;
      l_rdata_q    <= '0;
      c_ack_q      <= 1'b0;
      l_ack_q      <= 1'b0;
      m_ena_q      <= 1'b0;
      m_w_q        <= 1'b0;
      m_r_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          c_ack_q <= 1'b0;
          l_ack_q <= 1'b0;
          if (c_req | l_req) begin
            owner_q <= grant_l_d ? PORT_L : PORT_C;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= CNT_INIT;
            m_ena_q <= 1'b1;
            m_w_q   <= we_d;
            m_r_q   <= ~we_d;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) begin
              if (owner_q == PORT_L) l_rdata_q <= m_rdata;
              else                   c_rdata_q <= m_rdata;
            end
            m_ena_q <= 1'b0;
            m_w_q   <= 1'b0;
            m_r_q   <= 1'b0;
            c_ack_q <= (owner_q == PORT_C);
            l_ack_q <= (owner_q == PORT_L);
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          c_ack_q      <= 1'b0;
          l_ack_q      <= 1'b0;
          last_grant_q <= owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_rdata   = c_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign c_ack     = c_ack_q;
  assign l_ack     = l_ack_q;
  assign m_ena     = m_ena_q;
  assign m_w       = m_w_q;
  assign m_r       = m_r_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  // The CPU is released in its ack cycle so it advances exactly one step.
  assign cpu_stall = c_req & ~c_ack_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with fixed cycle expectations, then
// random traffic checked against a cycle-arithmetic transaction model.
module tb_dmem_arbiter;
  localparam int LAT   = 2;
  localparam int NRAND = 3000;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, c_ack;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        l_req, l_we, l_ack;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        m_ena, m_w, m_r;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        cpu_stall, busy;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  int checks = 0;
  int errors = 0;
  int t      = 0;

  // random-phase model state
  int          cur_start;
  logic        cur_owner, cur_we, last_grant;
  logic [31:0] cur_addr, cur_wdata, exp_c_rdata, exp_l_rdata;
  logic        in_acc, is_done, ack_prev_c, ack_prev_l, c_pend, l_pend, g;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack),
    .m_ena(m_ena), .m_w(m_w), .m_r(m_r), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata),
    .cpu_stall(cpu_stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: combinational read, write on the clock edge while strobed.
  assign m_rdata = mem[m_addr[7:0]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[8'h10] = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      if (m_ena && m_w) mem[m_addr[7:0]] <= m_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    #2;
    chk("rst_m_ena", m_ena, 0);
    chk("rst_m_w", m_w, 0);
    chk("rst_m_r", m_r, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_c_ack", c_ack, 0);
    chk("rst_l_ack", l_ack, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
  endtask

  // One isolated transaction starting at the current cycle (which must be IDLE).
  task automatic single(input bit is_l, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input bit withdraw);
    if (is_l) begin l_req = 1; l_we = we; l_addr = addr; l_wdata = wdata; end
    else      begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    for (int k = 0; k < 4; k++) begin
      if (withdraw && k == 1) begin
        if (is_l) begin l_req = 0; l_addr = addr + 1; l_wdata = ~wdata; end
        else      begin c_req = 0; c_addr = addr + 1; c_wdata = ~wdata; end
      end
      mid();
      chk("s_m_ena", m_ena, (k == 1 || k == 2));
      chk("s_m_w", m_w, (k == 1 || k == 2) && we);
      chk("s_m_r", m_r, (k == 1 || k == 2) && !we);
      if (k == 1 || k == 2) chk("s_m_addr", m_addr, addr);
      if ((k == 1 || k == 2) && we) chk("s_m_wdata", m_wdata, wdata);
      chk("s_c_ack", c_ack, !is_l && k == 3);
      chk("s_l_ack", l_ack, is_l && k == 3);
      chk("s_stall", cpu_stall, !is_l && !(withdraw && k >= 1) && k < 3);
      if (k == 3) chk("s_rdata", is_l ? l_rdata : c_rdata, exp_rd);
      cyc();
    end
    c_req = 0;
    l_req = 0;
  endtask

  initial begin
    // CPU read of 0x10
    do_reset();
    single(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);

    // Loader read then write; the write must leave l_rdata alone
    single(1, 0, 32'h30, 32'h0, 32'hC0DE_0030, 0);
    single(1, 1, 32'h20, 32'h1234_5678, 32'hC0DE_0030, 0);
    chk("mem_0x20", mem[8'h20], 32'h1234_5678);

    // Both requesting continuously from reset: C, L, C, L
    do_reset();
    c_req = 1; c_we = 0; c_addr = 32'h1;
    l_req = 1; l_we = 0; l_addr = 32'h2;
    for (int k = 0; k < 16; k++) begin
      mid();
      chk("rr_c_ack", c_ack, (k % 4 == 3) && ((k / 4) % 2 == 0));
      chk("rr_l_ack", l_ack, (k % 4 == 3) && ((k / 4) % 2 == 1));
      chk("rr_busy", busy, (k % 4 != 0));
      if (k % 4 == 1 || k % 4 == 2)
        chk("rr_m_addr", m_addr, ((k / 4) % 2 == 1) ? 32'h2 : 32'h1);
      if (k % 4 == 3 && (k / 4) % 2 == 0) chk("rr_c_rdata", c_rdata, 32'hC0DE_0001);
      if (k % 4 == 3 && (k / 4) % 2 == 1) chk("rr_l_rdata", l_rdata, 32'hC0DE_0002);
      cyc();
    end
    c_req = 0; l_req = 0;

    // CPU back-to-back reads of 0x0 then 0x4
    do_reset();
    c_req = 1; c_we = 0; c_addr = 32'h0;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) c_addr = 32'h4;
      mid();
      chk("b2b_c_ack", c_ack, (k == 3 || k == 7));
      chk("b2b_stall", cpu_stall, !(k == 3 || k == 7));
      if (k == 3) chk("b2b_rdata0", c_rdata, 32'hC0DE_0000);
      if (k == 7) chk("b2b_rdata4", c_rdata, 32'hC0DE_0004);
      cyc();
    end
    c_req = 0;

    // Reset in cycle 2 of a CPU write, then a tie must go to C
    do_reset();
    c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hBAD0_0040;
    cyc();
    cyc();
    mid();
    chk("ra_m_w_c2", m_w, 1);
    #1 rst = 1'b1;
    #1;
    chk("ra_m_ena", m_ena, 0);
    chk("ra_m_w", m_w, 0);
    chk("ra_busy", busy, 0);
    chk("ra_c_ack", c_ack, 0);
    l_req = 1; l_we = 0; l_addr = 32'h50;
    @(posedge clk);
    #1;
    chk("ra_c_ack_hold", c_ack, 0);
    rst = 1'b0;
    t = 0;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("ra_c_ack2", c_ack, (k == 3));
      chk("ra_l_ack2", l_ack, 0);
      if (k == 1) chk("ra_m_addr", m_addr, 32'h40);
      cyc();
    end
    c_req = 0; l_req = 0;

    // Loader withdraws and changes address during ACCESS
    do_reset();
    single(1, 0, 32'h60, 32'h0, 32'hC0DE_0060, 1);

    // Random traffic against the transaction model
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    cur_start = -1; cur_owner = 0; cur_we = 0; cur_addr = 0; cur_wdata = 0;
    last_grant = 1; exp_c_rdata = 0; exp_l_rdata = 0;
    ack_prev_c = 0; ack_prev_l = 0; c_pend = 0; l_pend = 0;
    for (int n = 0; n < NRAND; n++) begin
      in_acc = (cur_start >= 0) && (t > cur_start) && (t <= cur_start + LAT);
      if (ack_prev_c || !c_pend) begin
        c_pend = ($urandom_range(0, 99) < 45);
        c_req = c_pend;
        c_we = $urandom_range(0, 1); c_addr = $urandom_range(0, 15); c_wdata = $urandom;
      end else if (in_acc && cur_owner == 0) begin
        if ($urandom_range(0, 3) == 0) c_req = 0;
        if ($urandom_range(0, 1) == 1) begin
          c_we = ~c_we; c_addr = $urandom_range(0, 15); c_wdata = $urandom;
        end
      end
      if (ack_prev_l || !l_pend) begin
        l_pend = ($urandom_range(0, 99) < 45);
        l_req = l_pend;
        l_we = $urandom_range(0, 1); l_addr = $urandom_range(0, 15); l_wdata = $urandom;
      end else if (in_acc && cur_owner == 1) begin
        if ($urandom_range(0, 3) == 0) l_req = 0;
        if ($urandom_range(0, 1) == 1) begin
          l_we = ~l_we; l_addr = $urandom_range(0, 15); l_wdata = $urandom;
        end
      end
      ack_prev_c = 0;
      ack_prev_l = 0;
      mid();
      is_done = (cur_start >= 0) && (t == cur_start + LAT + 1);
      if (is_done) begin
        if (cur_we) ref_mem[cur_addr[7:0]] = cur_wdata;
        else if (cur_owner) exp_l_rdata = ref_mem[cur_addr[7:0]];
        else exp_c_rdata = ref_mem[cur_addr[7:0]];
        last_grant = cur_owner;
        ack_prev_c = !cur_owner;
        ack_prev_l = cur_owner;
      end
      chk("rnd_busy", busy, in_acc || is_done);
      chk("rnd_m_ena", m_ena, in_acc);
      chk("rnd_m_w", m_w, in_acc && cur_we);
      chk("rnd_m_r", m_r, in_acc && !cur_we);
      if (in_acc) chk("rnd_m_addr", m_addr, cur_addr);
      if (in_acc && cur_we) chk("rnd_m_wdata", m_wdata, cur_wdata);
      chk("rnd_c_ack", c_ack, is_done && !cur_owner);
      chk("rnd_l_ack", l_ack, is_done && cur_owner);
      chk("rnd_c_rdata", c_rdata, exp_c_rdata);
      chk("rnd_l_rdata", l_rdata, exp_l_rdata);
      chk("rnd_stall", cpu_stall, c_req && !(is_done && !cur_owner));
      if (!in_acc && !is_done && (c_req || l_req)) begin
        g = l_req && (!c_req || last_grant == 0);
        cur_owner = g;
        cur_we    = g ? l_we : c_we;
        cur_addr  = g ? l_addr : c_addr;
        cur_wdata = g ? l_wdata : c_wdata;
        cur_start = t;
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
